// File: rtl/timer_pkg.sv
// Shared definitions for the wb_timer machine timer peripheral.
// Optional feature macro: WB_TIMER_PRESCALER_EN (enables the PRESCALE register).
package timer_pkg;

    // Word offsets decoded from adr_i[4:2]; 6 and 7 are unmapped
    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_MSIP        = 3'd4,
        REG_PRESCALE    = 3'd5
    } timer_reg_t;

    localparam int unsigned MSIP_BIT   = 0;
    localparam int unsigned PRESCALE_W = 16;

    // Replace the bytes of old_v selected by sel with the matching bytes of new_v
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// 64-bit mtime counter with tick generation and bus write override.
// With WB_TIMER_PRESCALER_EN defined a 16-bit prescaler divides the tick;
// otherwise mtime advances every cycle and no prescaler state exists.
module timer_counter
    import timer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_wr_lo,
    input  logic                  i_wr_hi,
    input  logic [31:0]           i_wdata,
`ifdef WB_TIMER_PRESCALER_EN
    input  logic                  i_psc_wr,
    input  logic [PRESCALE_W-1:0] i_psc_wdata,
    output logic [PRESCALE_W-1:0] o_prescale,
`endif
    output logic [63:0]           o_mtime
);

    logic [63:0] r_mtime;
    logic        w_tick;

`ifdef WB_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] r_count;
    logic [PRESCALE_W-1:0] r_prescale;

    assign w_tick     = (r_count == r_prescale);
    assign o_prescale = r_prescale;

    // Prescaler: count up to PRESCALE then restart; a PRESCALE write restarts the count
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count    <= '0;
            r_prescale <= '0;
        end else if (i_psc_wr) begin
            r_prescale <= i_psc_wdata;
            r_count    <= '0;
        end else if (w_tick) begin
            r_count    <= '0;
        end else begin
            r_count    <= r_count + PRESCALE_W'(1);
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // mtime: a bus write to either half wins over the tick and suppresses the increment
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mtime <= '0;
        end else if (i_wr_lo) begin
            r_mtime[31:0] <= i_wdata;
        end else if (i_wr_hi) begin
            r_mtime[63:32] <= i_wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    assign o_mtime = r_mtime;

endmodule

// File: rtl/wb_timer.sv
// Machine timer / software interrupt peripheral on a Wishbone-style bus.
// Bus decode, acknowledge and read data, mtimecmp, msip, mtime high shadow
// and the registered timer compare. Optional macro: WB_TIMER_PRESCALER_EN.
module wb_timer
    import timer_pkg::*;
#(
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        timer_interrupt_o,
    output logic        software_interrupt_o
);

    logic        r_ack;
    logic [31:0] r_data;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [31:0] r_shadow;
    logic        r_tint;
    logic        r_sint;

    logic        w_access;
    timer_reg_t  w_off;
    logic [63:0] w_mtime;
    logic [31:0] w_mtime_wdata;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic [31:0] w_rdata;
    logic        w_unused_adr;

    assign w_unused_adr = &{1'b0, adr_i[31:5], adr_i[1:0]};

    // stb_i still high during the ack cycle is the tail of the same access
    assign w_access = stb_i & ~r_ack;
    assign w_off    = timer_reg_t'(adr_i[4:2]);
    assign w_wr_lo  = w_access & we_i & (w_off == REG_MTIME_LO);
    assign w_wr_hi  = w_access & we_i & (w_off == REG_MTIME_HI);
    assign w_mtime_wdata = byte_merge((w_off == REG_MTIME_HI) ? w_mtime[63:32] : w_mtime[31:0],
                                      data_i, sel_i);

`ifdef WB_TIMER_PRESCALER_EN
    logic                  w_psc_wr;
    logic [PRESCALE_W-1:0] w_prescale;
    logic [31:0]           w_psc_merge;

    assign w_psc_wr    = w_access & we_i & (w_off == REG_PRESCALE);
    assign w_psc_merge = byte_merge({{(32-PRESCALE_W){1'b0}}, w_prescale}, data_i, sel_i);
`endif

    timer_counter u_counter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_wr_lo     (w_wr_lo),
        .i_wr_hi     (w_wr_hi),
        .i_wdata     (w_mtime_wdata),
`ifdef WB_TIMER_PRESCALER_EN
        .i_psc_wr    (w_psc_wr),
        .i_psc_wdata (w_psc_merge[PRESCALE_W-1:0]),
        .o_prescale  (w_prescale),
`endif
        .o_mtime     (w_mtime)
    );

    // Read data mux; MTIME_HI returns the shadow captured by the last MTIME_LO read
    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_MTIME_LO:    w_rdata = w_mtime[31:0];
            REG_MTIME_HI:    w_rdata = r_shadow;
            REG_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
            REG_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
            REG_MSIP:        w_rdata = {31'b0, r_msip};
`ifdef WB_TIMER_PRESCALER_EN
            REG_PRESCALE:    w_rdata = {{(32-PRESCALE_W){1'b0}}, w_prescale};
`endif
            default:         w_rdata = '0;
        endcase
    end

    // Bus access, register writes and interrupt outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack      <= 1'b0;
            r_data     <= '0;
            r_mtimecmp <= MTIMECMP_RESET;
            r_msip     <= 1'b0;
            r_shadow   <= '0;
            r_tint     <= 1'b0;
            r_sint     <= 1'b0;
        end else begin
            r_ack  <= w_access;
            r_tint <= (w_mtime >= r_mtimecmp);
            r_sint <= r_msip;
            if (w_access) begin
                if (we_i) begin
                    case (w_off)
                        REG_MTIME_HI:    r_shadow <= w_mtime_wdata;
                        REG_MTIMECMP_LO: r_mtimecmp[31:0]  <= byte_merge(r_mtimecmp[31:0], data_i, sel_i);
                        REG_MTIMECMP_HI: r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], data_i, sel_i);
                        REG_MSIP: begin
                            if (sel_i[MSIP_BIT/8]) r_msip <= data_i[MSIP_BIT];
                        end
                        default: ;
                    endcase
                end else begin
                    r_data <= w_rdata;
                    if (w_off == REG_MTIME_LO) r_shadow <= w_mtime[63:32];
                end
            end
        end
    end

    assign ack_o                = r_ack;
    assign data_o               = r_data;
    assign timer_interrupt_o    = r_tint;
    assign software_interrupt_o = r_sint;

endmodule
